// File: rtl/mem_responder_if.sv
// CPU-to-memory bus between the datapath and the memory-side responder.
//   req       level request, held by the master until ready is seen
//   rw        1 = read, 0 = write
//   address   16-bit byte address
//   wdata     write data (CPU data_out)
//   rdata     read data (CPU data_in), registered in the responder
//   ready     one-cycle completion pulse
//   bus_error pulses with ready on an unmapped access
interface mem_responder_if;
  logic        req;
  logic        rw;
  logic [15:0] address;
  logic [7:0]  wdata;
  logic [7:0]  rdata;
  logic        ready;
  logic        bus_error;

  modport master (
    output req, rw, address, wdata,
    input  rdata, ready, bus_error
  );

  modport slave (
    input  req, rw, address, wdata,
    output rdata, ready, bus_error
  );
endinterface

// File: rtl/mem_responder.sv
// Memory-side bus target: RAM, a 4-byte IO page and an unmapped region, with
// per-region wait states and a registered one-cycle ready pulse.
//   ph2    single clock, all state changes on the rising edge
//   reset  synchronous, active-high
//   bus    slave side of mem_responder_if (req/rw/address/wdata in,
//          rdata/ready/bus_error out, all outputs registered)
// IO page offsets: 0 scratch, 1 cycle counter low byte (read snapshots the
// high byte into shadow, write clears the counter), 2 shadow, 3 access count.
module mem_responder #(
  parameter int unsigned RAM_AW   = 10,
  parameter int unsigned RAM_WAIT = 0,
  parameter logic [15:0] IO_BASE  = 16'hD000,
  parameter int unsigned IO_WAIT  = 2
) (
  input logic            ph2,
  input logic            reset,
  mem_responder_if.slave bus
);

  localparam int unsigned RamWords = 1 << RAM_AW;

  typedef enum logic [1:0] {StIdle, StWait, StDone} state_e;
  typedef enum logic [1:0] {RegRam, RegIo, RegNone} region_e;

  state_e      state_q;
  logic [3:0]  wcnt_q;
  logic [15:0] addr_q;
  logic        rw_q;
  logic [7:0]  wdata_q;
  logic [7:0]  scratch_q;
  logic [7:0]  shadow_q;
  logic [7:0]  acc_cnt_q;
  logic [15:0] cyc_cnt_q;
  logic [7:0]  rdata_q;
  logic        ready_q;
  logic        bus_error_q;
  logic [7:0]  ram [RamWords];

  // The access being decoded: live bus inputs while idle (a zero-wait access
  // completes on its acceptance edge), the latched copy otherwise.
  logic [15:0] acc_addr;
  logic        acc_rw;
  logic [7:0]  acc_wdata;
  region_e     acc_region;
  logic [3:0]  acc_wait;
  logic        commit;

  always_comb begin
    acc_addr   = addr_q;
    acc_rw     = rw_q;
    acc_wdata  = wdata_q;
    if (state_q == StIdle) begin
      acc_addr  = bus.address;
      acc_rw    = bus.rw;
      acc_wdata = bus.wdata;
    end
    acc_region = RegNone;
    acc_wait   = 4'd0;
    if (32'(acc_addr) < RamWords) begin
      acc_region = RegRam;
      acc_wait   = 4'(RAM_WAIT);
    end else if (acc_addr[15:2] == IO_BASE[15:2]) begin
      acc_region = RegIo;
      acc_wait   = 4'(IO_WAIT);
    end
    // True on the edge that enters DONE: read data, write commit, counters.
    commit = ((state_q == StIdle) && bus.req && (acc_wait == 4'd0)) ||
             ((state_q == StWait) && (wcnt_q == 4'd1));
  end

  // RAM contents survive reset; only the commit is suppressed.
  always_ff @(posedge ph2) begin
    if (!reset && commit && !acc_rw && (acc_region == RegRam)) begin
      ram[acc_addr[RAM_AW-1:0]] <= acc_wdata;
    end
  end

  always_ff @(posedge ph2) begin
    if (reset) begin
      state_q     <= StIdle;
      wcnt_q      <= 4'd0;
      addr_q      <= 16'd0;
      rw_q        <= 1'b0;
      wdata_q     <= 8'd0;
      scratch_q   <= 8'd0;
      shadow_q    <= 8'd0;
      acc_cnt_q   <= 8'd0;
      cyc_cnt_q   <= 16'd0;
      rdata_q     <= 8'd0;
      ready_q     <= 1'b0;
      bus_error_q <= 1'b0;
    end else begin
      ready_q     <= 1'b0;
      bus_error_q <= 1'b0;
      cyc_cnt_q   <= cyc_cnt_q + 16'd1;

      unique case (state_q)
        StIdle: begin
          if (bus.req) begin
            addr_q  <= bus.address;
            rw_q    <= bus.rw;
            wdata_q <= bus.wdata;
            wcnt_q  <= acc_wait;
            state_q <= (acc_wait != 4'd0) ? StWait : StDone;
          end
        end
        StWait: begin
          wcnt_q <= wcnt_q - 4'd1;
          if (wcnt_q == 4'd1) state_q <= StDone;
        end
        StDone: state_q <= StIdle;
        default: state_q <= StIdle;
      endcase

      if (commit) begin
        ready_q   <= 1'b1;
        acc_cnt_q <= acc_cnt_q + 8'd1;
        unique case (acc_region)
          RegRam: begin
            if (acc_rw) rdata_q <= ram[acc_addr[RAM_AW-1:0]];
          end
          RegIo: begin
            unique case (acc_addr[1:0])
              2'd0: begin
                if (acc_rw) rdata_q <= scratch_q;
                else        scratch_q <= acc_wdata;
              end
              2'd1: begin
                if (acc_rw) begin
                  rdata_q  <= cyc_cnt_q[7:0];
                  shadow_q <= cyc_cnt_q[15:8];
                end else begin
                  cyc_cnt_q <= 16'd0;  // clear beats the increment above
                end
              end
              2'd2: begin
                if (acc_rw) rdata_q <= shadow_q;
              end
              default: begin
                if (acc_rw) rdata_q <= acc_cnt_q;
                else        acc_cnt_q <= acc_wdata;  // load beats the increment
              end
            endcase
          end
          default: begin
            bus_error_q <= 1'b1;
            if (acc_rw) rdata_q <= 8'hFF;
          end
        endcase
      end
    end
  end

  assign bus.rdata     = rdata_q;
  assign bus.ready     = ready_q;
  assign bus.bus_error = bus_error_q;

endmodule
